multi_timer: RTL and testbench

Parametrised multi-channel successor to the single-channel fabric timer, sitting on the same fabric register bus and driving the same fabric interrupt line (`fabint`). It adds the following:
- `NUM_CH` independent counters of width `CNT_W`.
- Per-channel one-shot mode.
- Optional per-channel prescaler.
- Sticky write-1-to-clear status flags.
- A level interrupt ORed across channels.
- A global pending-summary register.

---
 rtl/multi_timer.sv | 189 ++++++++++++++++++
 tb/tb_multi_timer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_timer.sv
// Multi-channel fabric timer: NUM_CH counters with one-shot mode, compare, W1C status and an ORed level interrupt.
// Optional per-channel 8-bit prescaler enabled by defining MULTI_TIMER_PRESCALE_EN.
module multi_timer #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 32
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic        bus_write_en,
  input  logic        bus_read_en,
  input  logic [7:0]  bus_addr,
  input  logic [31:0] bus_write_data,
  output logic [31:0] bus_read_data,
  output logic        fabint
);

  typedef enum logic [2:0] {
    REG_PERIOD  = 3'd0,
    REG_COUNT   = 3'd1,
    REG_CTRL    = 3'd2,
    REG_COMPARE = 3'd3,
    REG_STATUS  = 3'd4,
    REG_PENDING = 3'd5
  } reg_e;

  logic [2:0] ch_sel, reg_sel;
  logic       ch_ok, wr, rd;

  logic [NUM_CH-1:0][CNT_W-1:0] period_q, period_d, compare_q, compare_d, count_q, count_d;
  logic [NUM_CH-1:0] en_q, en_d, ie_q, ie_d, cmpen_q, cmpen_d, ovfen_q, ovfen_d;
  logic [NUM_CH-1:0] oneshot_q, oneshot_d, ovf_q, ovf_d, cmp_q, cmp_d;
  logic [NUM_CH-1:0] sel, tick, set_ovf, set_cmp, clr_ovf, clr_cmp, pend;
`ifdef MULTI_TIMER_PRESCALE_EN
  logic [NUM_CH-1:0][7:0] prescale_q, prescale_d, psc_q, psc_d;
`endif
  logic [31:0] rdata_q, rdata_d;
  logic        fabint_q, fabint_d;

  assign ch_sel  = bus_addr[7:5];
  assign reg_sel = bus_addr[4:2];
  assign ch_ok   = 32'(ch_sel) < NUM_CH;
  assign wr      = bus_write_en & ch_ok;
  assign rd      = bus_read_en & ~bus_write_en;
  assign pend    = ie_q & (ovf_q | cmp_q);

  assign bus_read_data = rdata_q;
  assign fabint        = fabint_q;

  logic unused_bits;
  assign unused_bits = ^{bus_addr[1:0], bus_write_data};

  always_comb begin
    period_d  = period_q;
    compare_d = compare_q;
    count_d   = count_q;
    en_d      = en_q;
    ie_d      = ie_q;
    cmpen_d   = cmpen_q;
    ovfen_d   = ovfen_q;
    oneshot_d = oneshot_q;
    sel       = '0;
    tick      = '0;
    set_ovf   = '0;
    set_cmp   = '0;
    clr_ovf   = '0;
    clr_cmp   = '0;
`ifdef MULTI_TIMER_PRESCALE_EN
    prescale_d = prescale_q;
    psc_d      = psc_q;
`endif
    fabint_d  = |pend;

    for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
      sel[ch] = wr && (32'(ch_sel) == ch);
`ifdef MULTI_TIMER_PRESCALE_EN
      tick[ch] = en_q[ch] && (psc_q[ch] == prescale_q[ch]);
      if (en_q[ch])
        psc_d[ch] = tick[ch] ? 8'd0 : psc_q[ch] + 8'd1;
`else
      tick[ch] = en_q[ch];
`endif
      set_ovf[ch] = tick[ch] && ovfen_q[ch] && (count_q[ch] == period_q[ch]);
      set_cmp[ch] = tick[ch] && cmpen_q[ch] && (count_q[ch] == compare_q[ch]);
      if (tick[ch]) begin
        if (count_q[ch] == period_q[ch]) begin
          count_d[ch] = '0;
          if (oneshot_q[ch])
            en_d[ch] = 1'b0;
        end else begin
          count_d[ch] = count_q[ch] + 1'b1;
        end
      end

      // Bus writes come after the tick update so they override it at the same edge.
      if (sel[ch]) begin
        case (reg_sel)
          REG_PERIOD: begin
            period_d[ch] = bus_write_data[CNT_W-1:0];
            count_d[ch]  = '0;
`ifdef MULTI_TIMER_PRESCALE_EN
            psc_d[ch]    = '0;
`endif
          end
          REG_CTRL: begin
            en_d[ch]      = bus_write_data[0];
            ie_d[ch]      = bus_write_data[1];
            cmpen_d[ch]   = bus_write_data[2];
            ovfen_d[ch]   = bus_write_data[3];
            oneshot_d[ch] = bus_write_data[4];
`ifdef MULTI_TIMER_PRESCALE_EN
            prescale_d[ch] = bus_write_data[15:8];
`endif
          end
          REG_COMPARE: compare_d[ch] = bus_write_data[CNT_W-1:0];
          REG_STATUS: begin
            clr_ovf[ch] = bus_write_data[0];
            clr_cmp[ch] = bus_write_data[1];
          end
          default: ;
        endcase
      end
    end

    ovf_d = (ovf_q & ~clr_ovf) | set_ovf;
    cmp_d = (cmp_q & ~clr_cmp) | set_cmp;

    rdata_d = rdata_q;
    if (rd) begin
      rdata_d = '0;
      for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
        if (ch_ok && (32'(ch_sel) == ch)) begin
          case (reg_sel)
            REG_PERIOD:  rdata_d[CNT_W-1:0] = period_q[ch];
            REG_COUNT:   rdata_d[CNT_W-1:0] = count_q[ch];
            REG_CTRL: begin
              rdata_d[4:0] = {oneshot_q[ch], ovfen_q[ch], cmpen_q[ch], ie_q[ch], en_q[ch]};
`ifdef MULTI_TIMER_PRESCALE_EN
              rdata_d[15:8] = prescale_q[ch];
`endif
            end
            REG_COMPARE: rdata_d[CNT_W-1:0] = compare_q[ch];
            REG_STATUS:  rdata_d[1:0] = {cmp_q[ch], ovf_q[ch]};
            REG_PENDING: rdata_d[NUM_CH-1:0] = pend;
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      period_q  <= '0;
      compare_q <= '0;
      count_q   <= '0;
      en_q      <= '0;
      ie_q      <= '0;
      cmpen_q   <= '0;
      ovfen_q   <= '0;
      oneshot_q <= '0;
      ovf_q     <= '0;
      cmp_q     <= '0;
`ifdef MULTI_TIMER_PRESCALE_EN
      prescale_q <= '0;
      psc_q      <= '0;
`endif
      rdata_q   <= '0;
      fabint_q  <= 1'b0;
    end else begin
      period_q  <= period_d;
      compare_q <= compare_d;
      count_q   <= count_d;
      en_q      <= en_d;
      ie_q      <= ie_d;
      cmpen_q   <= cmpen_d;
      ovfen_q   <= ovfen_d;
      oneshot_q <= oneshot_d;
      ovf_q     <= ovf_d;
      cmp_q     <= cmp_d;
`ifdef MULTI_TIMER_PRESCALE_EN
      prescale_q <= prescale_d;
      psc_q      <= psc_d;
`endif
      rdata_q   <= rdata_d;
      fabint_q  <= fabint_d;
    end
  end

endmodule

// File: tb/tb_multi_timer.sv
// Directed bench for multi_timer: register table plus hand-timed counter/interrupt sequences.
// A second CNT_W=8 instance shares the bus stimulus for the width/wrap checks.
module tb_multi_timer;

  logic        pclk = 1'b0;
  logic        reset;
  logic        bus_write_en, bus_read_en;
  logic [7:0]  bus_addr;
  logic [31:0] bus_write_data;
  logic [31:0] rdata, rdata8;
  logic        fabint, fabint8;

  int passed = 0;
  int total  = 0;

  always #5 pclk = ~pclk;

  multi_timer #(.NUM_CH(4), .CNT_W(32)) u_dut (
    .pclk(pclk), .reset(reset), .bus_write_en(bus_write_en), .bus_read_en(bus_read_en),
    .bus_addr(bus_addr), .bus_write_data(bus_write_data),
    .bus_read_data(rdata), .fabint(fabint)
  );

  multi_timer #(.NUM_CH(4), .CNT_W(8)) u_dut8 (
    .pclk(pclk), .reset(reset), .bus_write_en(bus_write_en), .bus_read_en(bus_read_en),
    .bus_addr(bus_addr), .bus_write_data(bus_write_data),
    .bus_read_data(rdata8), .fabint(fabint8)
  );

  typedef struct {
    bit          wr;
    int unsigned ch;
    int unsigned rg;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

`ifdef MULTI_TIMER_PRESCALE_EN
  localparam logic [31:0] CTRL_RB = 32'h0000_FF1E;
`else
  localparam logic [31:0] CTRL_RB = 32'h0000_001E;
`endif

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
  endtask

  // All bus tasks start and end on a falling edge, consuming exactly one rising edge.
  task automatic wr(input int unsigned ch, input int unsigned rg, input logic [31:0] d);
    bus_addr       = {ch[2:0], rg[2:0], 2'b00};
    bus_write_data = d;
    bus_write_en   = 1'b1;
    @(negedge pclk);
    bus_write_en   = 1'b0;
  endtask

  task automatic chk_rd(input string name, input int unsigned ch, input int unsigned rg,
                        input logic [31:0] exp);
    bus_addr    = {ch[2:0], rg[2:0], 2'b00};
    bus_read_en = 1'b1;
    @(negedge pclk);
    bus_read_en = 1'b0;
    check(name, rdata, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge pclk);
  endtask

  vec_t tbl[$];

  initial begin
    reset = 1'b1;
    bus_write_en = 1'b0;
    bus_read_en = 1'b0;
    bus_addr = '0;
    bus_write_data = '0;
    repeat (2) @(negedge pclk);
    reset = 1'b0;

    // Reset state
    check("reset rdata", rdata, 32'h0);
    check("reset fabint", {31'd0, fabint}, 32'h0);
    check("reset fabint8", {31'd0, fabint8}, 32'h0);
    for (int c = 0; c < 8; c++)
      for (int r = 0; r < 8; r++)
        chk_rd($sformatf("reset ch%0d r%0d", c, r), c, r, 32'h0);

    // Register access table (all channels disabled)
    tbl.push_back('{1'b1, 0, 0, 32'h1234_5678, 32'h0});
    tbl.push_back('{1'b0, 0, 0, 32'h0, 32'h1234_5678});
    tbl.push_back('{1'b1, 1, 3, 32'hDEAD_BEEF, 32'h0});
    tbl.push_back('{1'b0, 1, 3, 32'h0, 32'hDEAD_BEEF});
    tbl.push_back('{1'b1, 3, 2, 32'hFFFF_FF1E, 32'h0});
    tbl.push_back('{1'b0, 3, 2, 32'h0, CTRL_RB});
    tbl.push_back('{1'b1, 2, 1, 32'h0000_0055, 32'h0});
    tbl.push_back('{1'b0, 2, 1, 32'h0, 32'h0});
    tbl.push_back('{1'b1, 0, 7, 32'h0000_FFFF, 32'h0});
    tbl.push_back('{1'b0, 0, 7, 32'h0, 32'h0});
    tbl.push_back('{1'b0, 0, 6, 32'h0, 32'h0});
    tbl.push_back('{1'b1, 7, 0, 32'h0000_00AB, 32'h0});
    tbl.push_back('{1'b0, 7, 0, 32'h0, 32'h0});
    tbl.push_back('{1'b0, 3, 0, 32'h0, 32'h0});
    tbl.push_back('{1'b0, 4, 2, 32'h0, 32'h0});
    tbl.push_back('{1'b0, 0, 5, 32'h0, 32'h0});
    tbl.push_back('{1'b1, 0, 4, 32'h0000_0003, 32'h0});
    tbl.push_back('{1'b0, 0, 4, 32'h0, 32'h0});
    foreach (tbl[i]) begin
      if (tbl[i].wr) wr(tbl[i].ch, tbl[i].rg, tbl[i].data);
      else chk_rd($sformatf("tbl[%0d] ch%0d r%0d", i, tbl[i].ch, tbl[i].rg),
                  tbl[i].ch, tbl[i].rg, tbl[i].exp);
    end

    // Periodic overflow on ch0: PERIOD=3, EN|IE|OVF_EN; first OVF at edge B+4
    wr(0, 0, 32'd3);
    wr(0, 2, 32'h0B);
    idle(2);
    chk_rd("per status B+3", 0, 4, 32'h0);
    check("per fabint B+3", {31'd0, fabint}, 32'h0);
    chk_rd("per status B+4", 0, 4, 32'h0);
    chk_rd("per status B+5", 0, 4, 32'h1);
    check("per fabint B+5", {31'd0, fabint}, 32'h1);
    wr(0, 4, 32'h1);
    check("per fabint at w1c", {31'd0, fabint}, 32'h1);
    idle(1);
    check("per fabint after w1c", {31'd0, fabint}, 32'h0);
    chk_rd("per status B+8", 0, 4, 32'h0);
    chk_rd("per status B+9", 0, 4, 32'h1);
    check("per fabint B+9", {31'd0, fabint}, 32'h1);
    wr(0, 2, 32'h08);
    idle(1);
    check("per ie masked", {31'd0, fabint}, 32'h0);
    chk_rd("per flag kept", 0, 4, 32'h1);
    wr(0, 4, 32'h3);

    // Compare plus one-shot on ch2: PERIOD=9, COMPARE=4, CTRL=0x17
    wr(2, 0, 32'd9);
    wr(2, 3, 32'd4);
    wr(2, 2, 32'h17);
    idle(4);
    chk_rd("os status B+5", 2, 4, 32'h0);
    chk_rd("os status B+6", 2, 4, 32'h2);
    check("os fabint", {31'd0, fabint}, 32'h1);
    idle(3);
    chk_rd("os ctrl B+10", 2, 2, 32'h17);
    chk_rd("os ctrl B+11", 2, 2, 32'h16);
    chk_rd("os count B+12", 2, 1, 32'h0);
    idle(3);
    chk_rd("os count idle", 2, 1, 32'h0);
    chk_rd("os status final", 2, 4, 32'h2);
    wr(2, 2, 32'h0);
    wr(2, 4, 32'h3);
    idle(1);
    check("os fabint cleared", {31'd0, fabint}, 32'h0);

    // Multi-channel interrupt: ch1 and ch3 overflow with IE
    wr(1, 0, 32'd1);
    wr(1, 2, 32'h0B);
    wr(3, 0, 32'd2);
    wr(3, 2, 32'h0B);
    idle(4);
    wr(1, 2, 32'h0A);
    wr(3, 2, 32'h0A);
    chk_rd("mc pending via ch0", 0, 5, 32'h0A);
    chk_rd("mc pending via ch2", 2, 5, 32'h0A);
    check("mc fabint both", {31'd0, fabint}, 32'h1);
    wr(1, 4, 32'h1);
    idle(1);
    check("mc fabint ch3 only", {31'd0, fabint}, 32'h1);
    chk_rd("mc pending ch3", 3, 5, 32'h08);
    wr(3, 4, 32'h1);
    idle(1);
    check("mc fabint none", {31'd0, fabint}, 32'h0);
    chk_rd("mc pending none", 1, 5, 32'h0);

    // Same-cycle tick set and W1C on ch1 (PERIOD=0 sets OVF every tick)
    wr(1, 0, 32'd0);
    wr(1, 2, 32'h09);
    wr(1, 4, 32'h1);
    chk_rd("set beats clear", 1, 4, 32'h1);
    wr(1, 2, 32'h0);
    wr(1, 4, 32'h1);
    chk_rd("clear when idle", 1, 4, 32'h0);

`ifdef MULTI_TIMER_PRESCALE_EN
    // Prescaler on ch0: PERIOD=1, PRESCALE=2 -> OVF every 6 cycles
    wr(0, 0, 32'd1);
    wr(0, 2, 32'h0209);
    idle(5);
    chk_rd("psc status B+6", 0, 4, 32'h0);
    chk_rd("psc status B+7", 0, 4, 32'h1);
    chk_rd("psc ctrl", 0, 2, 32'h0209);
    wr(0, 4, 32'h1);
    idle(2);
    chk_rd("psc status B+12", 0, 4, 32'h0);
    chk_rd("psc status B+13", 0, 4, 32'h1);
    idle(2);
    chk_rd("psc count B+16", 0, 1, 32'h1);
    wr(0, 0, 32'd5);
    chk_rd("psc count B+18", 0, 1, 32'h0);
    chk_rd("psc count B+19", 0, 1, 32'h0);
    chk_rd("psc count B+20", 0, 1, 32'h0);
    chk_rd("psc count B+21", 0, 1, 32'h1);
    wr(0, 2, 32'h0);
    wr(0, 4, 32'h3);
`endif

    // Bounds: CNT_W=8 instance truncates PERIOD and wraps 0xFF -> 0
    wr(0, 0, 32'h1FF);
    chk_rd("w32 period", 0, 0, 32'h1FF);
    check("w8 period", rdata8, 32'hFF);
    wr(0, 2, 32'h09);
    idle(254);
    chk_rd("w32 count B+255", 0, 1, 32'hFE);
    check("w8 count B+255", rdata8, 32'hFE);
    chk_rd("w32 count B+256", 0, 1, 32'hFF);
    check("w8 count B+256", rdata8, 32'hFF);
    chk_rd("w32 status B+257", 0, 4, 32'h0);
    check("w8 status B+257", rdata8, 32'h1);
    chk_rd("w32 count B+258", 0, 1, 32'h101);
    check("w8 count B+258", rdata8, 32'h1);
    wr(0, 2, 32'h0);

    // Reset mid-count discards everything
    wr(0, 0, 32'd5);
    wr(0, 2, 32'h0B);
    idle(3);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    check("rst2 rdata", rdata, 32'h0);
    check("rst2 fabint", {31'd0, fabint}, 32'h0);
    chk_rd("rst2 count", 0, 1, 32'h0);
    chk_rd("rst2 ctrl", 0, 2, 32'h0);
    chk_rd("rst2 period", 0, 0, 32'h0);
    chk_rd("rst2 status", 0, 4, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
